synapse316_uart_v3: RTL and testbench

Single-clock, parametrised full-duplex UART with an integrated baud generator, TX/RX FIFOs, optional parity, per-character error flags and sticky overflow status. It is the next-generation serial peripheral for the synapse316 register bus. It replaces the two-clock design (separate 4x-bit-rate clock and dual-clock FIFOs) with one sysclk domain and a programmable quarter-bit tick. It plugs into the same bus ports: data_in, load/read strobes and a 16-bit status word.

---
 rtl/synapse316_uart_pkg.sv | 26 ++
 rtl/synapse316_sync_fifo.sv | 51 +++++
 rtl/synapse316_uart_v3.sv | 228 ++++++++++++++++++++++
 tb/tb_synapse316_uart_v3.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/synapse316_uart_pkg.sv
// Shared constants, state encodings and the parity helper for the synapse316 UART.
package synapse316_uart_pkg;

  localparam int ST_RX_EMPTY     = 0;
  localparam int ST_RX_FULL      = 1;
  localparam int ST_RX_BUSY      = 2;
  localparam int ST_TX_EMPTY     = 3;
  localparam int ST_TX_FULL      = 4;
  localparam int ST_TX_BUSY      = 5;
  localparam int ST_RX_OVERRUN   = 6;
  localparam int ST_TX_OVERFLOW  = 7;
  localparam int ST_RX_COUNT_LSB = 8;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  // Data is zero-extended to 9 bits, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [8:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/synapse316_sync_fifo.sv
// Single-clock show-ahead FIFO; a pop frees the slot for a push in the same cycle.
module synapse316_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rdata,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  logic [WIDTH-1:0]      mem [1 << DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = count[DEPTH_LOG2];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (DEPTH_LOG2+1)'(1);
        2'b01:   count <= count - (DEPTH_LOG2+1)'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage has no reset; empty slots are never visible because rdata is masked by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/synapse316_uart_v3.sv
// Single-clock full-duplex UART: quarter-bit tick generator, TX/RX FSMs, two FIFOs, status word.
module synapse316_uart_v3
  import synapse316_uart_pkg::*;
#(
  parameter int          DATA_BITS        = 8,
  parameter int          FIFO_DEPTH_LOG2  = 4,
  parameter int          PARITY_MODE      = 0,
  parameter logic [15:0] DEFAULT_DIVISOR  = 16'd54,
  parameter logic        LINE_IDLE_LEVEL  = 1'b1,
  parameter logic        LINE_DATA_INVERT = 1'b0
) (
  input  logic        sysclk,
  input  logic        sysreset,
  input  logic        async_rx_line,
  output logic        async_tx_line,
  input  logic [15:0] data_in,
  input  logic        atx_reg_load,
  input  logic        divisor_load,
  input  logic        status_clear,
  output logic [15:0] arx_reg_out,
  input  logic        arx_reg_read,
  output logic [15:0] status_out,
  output logic        arx_fifo_empty,
  output logic        arx_fifo_full,
  output logic        arx_busy
);

  logic [15:0] divisor, tick_cnt, div_eff;
  logic        tick;

  assign div_eff = (divisor == '0) ? 16'd1 : divisor;
  assign tick    = (tick_cnt == div_eff - 16'd1);

  logic                       tx_pop, tx_full, tx_empty, tx_avail;
  logic [DATA_BITS-1:0]       tx_head;
  logic [FIFO_DEPTH_LOG2:0]   tx_count;
  logic                       rx_push, rx_full, rx_empty;
  logic [15:0]                rx_word;
  logic [FIFO_DEPTH_LOG2:0]   rx_count;
  logic                       rx_ovr, tx_ovf;

  synapse316_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_tx_fifo (
    .clk(sysclk), .rst(sysreset), .push(atx_reg_load), .wdata(data_in[DATA_BITS-1:0]),
    .pop(tx_pop), .rdata(tx_head), .count(tx_count), .full(tx_full), .empty(tx_empty)
  );

  synapse316_sync_fifo #(.WIDTH(16), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_rx_fifo (
    .clk(sysclk), .rst(sysreset), .push(rx_push), .wdata(rx_word),
    .pop(arx_reg_read), .rdata(arx_reg_out), .count(rx_count), .full(rx_full), .empty(rx_empty)
  );

  assign tx_avail = (tx_count != '0);

  // ---------------- transmitter ----------------
  tx_state_t            tx_state, tx_state_n;
  logic [1:0]           tx_qcnt, tx_qcnt_n;
  logic [3:0]           tx_bit, tx_bit_n;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
  logic                 tx_par, tx_par_n, tx_line_n;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    tx_state_n = tx_state;
    tx_qcnt_n  = tx_qcnt;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_par_n   = tx_par;
    tx_line_n  = async_tx_line;
    tx_pop     = 1'b0;
    if (tick) begin
      tx_qcnt_n = tx_qcnt + 2'd1;
      unique case (tx_state)
        TX_IDLE: begin
          tx_qcnt_n = '0;
          if (tx_avail) begin
            tx_pop     = 1'b1;
            tx_shift_n = tx_head;
            tx_par_n   = parity_bit(9'(tx_head), PARITY_MODE);
            tx_bit_n   = '0;
            tx_state_n = TX_START;
            tx_line_n  = ~LINE_IDLE_LEVEL;
          end
        end
        TX_START: if (tx_qcnt == 2'd3) begin
          tx_state_n = TX_DATA;
          tx_line_n  = tx_shift[0] ^ LINE_DATA_INVERT;
        end
        TX_DATA: if (tx_qcnt == 2'd3) begin
          if (tx_bit == 4'(DATA_BITS-1)) begin
            if (PARITY_MODE != PARITY_NONE) begin
              tx_state_n = TX_PARITY;
              tx_line_n  = tx_par ^ LINE_DATA_INVERT;
            end else begin
              tx_state_n = TX_STOP;
              tx_line_n  = LINE_IDLE_LEVEL;
            end
          end else begin
            tx_bit_n   = tx_bit + 4'd1;
            tx_shift_n = tx_shift >> 1;
            tx_line_n  = tx_shift[1] ^ LINE_DATA_INVERT;
          end
        end
        TX_PARITY: if (tx_qcnt == 2'd3) begin
          tx_state_n = TX_STOP;
          tx_line_n  = LINE_IDLE_LEVEL;
        end
        TX_STOP: if (tx_qcnt == 2'd3) tx_state_n = TX_IDLE;
        default: tx_state_n = TX_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  rx_state_t            rx_state, rx_state_n;
  logic [1:0]           rx_qcnt, rx_qcnt_n;
  logic [3:0]           rx_bit, rx_bit_n;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
  logic                 rx_par, rx_par_n, rx_meta, rx_sync, rx_val;

  assign rx_val = rx_sync ^ LINE_DATA_INVERT;

  always_comb begin
    rx_state_n = rx_state;
    rx_qcnt_n  = rx_qcnt;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_par_n   = rx_par;
    rx_push    = 1'b0;
    rx_word    = '0;
    rx_word[DATA_BITS-1:0] = rx_shift;
    rx_word[15] = (PARITY_MODE != PARITY_NONE) && (rx_par != parity_bit(9'(rx_shift), PARITY_MODE));
    rx_word[14] = (rx_sync != LINE_IDLE_LEVEL);
    if (tick) begin
      rx_qcnt_n = rx_qcnt + 2'd1;
      unique case (rx_state)
        RX_IDLE: begin
          rx_qcnt_n = '0;
          if (rx_sync != LINE_IDLE_LEVEL) rx_state_n = RX_START;
        end
        // Mid-start re-check: a line already back at idle was only a glitch.
        RX_START: if (rx_qcnt == 2'd1) begin
          rx_qcnt_n  = '0;
          rx_bit_n   = '0;
          rx_state_n = (rx_sync == LINE_IDLE_LEVEL) ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (rx_qcnt == 2'd3) begin
          rx_shift_n = {rx_val, rx_shift[DATA_BITS-1:1]};
          if (rx_bit == 4'(DATA_BITS-1))
            rx_state_n = (PARITY_MODE != PARITY_NONE) ? RX_PARITY : RX_STOP;
          else
            rx_bit_n = rx_bit + 4'd1;
        end
        RX_PARITY: if (rx_qcnt == 2'd3) begin
          rx_par_n   = rx_val;
          rx_state_n = RX_STOP;
        end
        RX_STOP: if (rx_qcnt == 2'd3) begin
          rx_push    = 1'b1;
          rx_state_n = RX_IDLE;
        end
        default: rx_state_n = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      divisor       <= DEFAULT_DIVISOR;
      tick_cnt      <= '0;
      tx_state      <= TX_IDLE;
      tx_qcnt       <= '0;
      tx_bit        <= '0;
      tx_shift      <= '0;
      tx_par        <= 1'b0;
      async_tx_line <= LINE_IDLE_LEVEL;
      rx_meta       <= LINE_IDLE_LEVEL;
      rx_sync       <= LINE_IDLE_LEVEL;
      rx_state      <= RX_IDLE;
      rx_qcnt       <= '0;
      rx_bit        <= '0;
      rx_shift      <= '0;
      rx_par        <= 1'b0;
      rx_ovr        <= 1'b0;
      tx_ovf        <= 1'b0;
    end else begin
      if (divisor_load) begin
        divisor  <= data_in;
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick ? 16'd0 : tick_cnt + 16'd1;
      end
      tx_state      <= tx_state_n;
      tx_qcnt       <= tx_qcnt_n;
      tx_bit        <= tx_bit_n;
      tx_shift      <= tx_shift_n;
      tx_par        <= tx_par_n;
      async_tx_line <= tx_line_n;
      rx_meta       <= async_rx_line;
      rx_sync       <= rx_meta;
      rx_state      <= rx_state_n;
      rx_qcnt       <= rx_qcnt_n;
      rx_bit        <= rx_bit_n;
      rx_shift      <= rx_shift_n;
      rx_par        <= rx_par_n;
      // A new drop event wins over a same-cycle clear.
      rx_ovr <= (rx_push && rx_full && !arx_reg_read) || (rx_ovr && !status_clear);
      tx_ovf <= (atx_reg_load && tx_full && !tx_pop) || (tx_ovf && !status_clear);
    end
  end

  always_comb begin
    status_out                       = '0;
    status_out[ST_RX_EMPTY]          = rx_empty;
    status_out[ST_RX_FULL]           = rx_full;
    status_out[ST_RX_BUSY]           = (rx_state != RX_IDLE);
    status_out[ST_TX_EMPTY]          = tx_empty;
    status_out[ST_TX_FULL]           = tx_full;
    status_out[ST_TX_BUSY]           = (tx_state != TX_IDLE);
    status_out[ST_RX_OVERRUN]        = rx_ovr;
    status_out[ST_TX_OVERFLOW]       = tx_ovf;
    status_out[ST_RX_COUNT_LSB +: 8] = 8'(rx_count);
  end

  assign arx_fifo_empty = status_out[ST_RX_EMPTY];
  assign arx_fifo_full  = status_out[ST_RX_FULL];
  assign arx_busy       = status_out[ST_RX_BUSY];

endmodule

// File: tb/tb_synapse316_uart_v3.sv
// Directed bench: an 8N1 instance (4-deep FIFOs) and an odd-parity instance driven side by side.
module tb_synapse316_uart_v3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, atx_load, div_load, stat_clr, rd_main, rd_odd;
  logic [15:0] data_in;
  logic        rx_main_drv, rx_odd, loop_en;
  logic        tx_main, tx_odd, rx_main;
  logic [15:0] arx_main, arx_odd, st_main, st_odd;
  logic        e_m, f_m, b_m, e_o, f_o, b_o;

  assign rx_main = loop_en ? tx_main : rx_main_drv;

  synapse316_uart_v3 #(.DATA_BITS(8), .FIFO_DEPTH_LOG2(2), .PARITY_MODE(0)) dut (
    .sysclk(clk), .sysreset(rst), .async_rx_line(rx_main), .async_tx_line(tx_main),
    .data_in(data_in), .atx_reg_load(atx_load), .divisor_load(div_load), .status_clear(stat_clr),
    .arx_reg_out(arx_main), .arx_reg_read(rd_main), .status_out(st_main),
    .arx_fifo_empty(e_m), .arx_fifo_full(f_m), .arx_busy(b_m)
  );

  synapse316_uart_v3 #(.DATA_BITS(8), .FIFO_DEPTH_LOG2(4), .PARITY_MODE(2)) dut_odd (
    .sysclk(clk), .sysreset(rst), .async_rx_line(rx_odd), .async_tx_line(tx_odd),
    .data_in(data_in), .atx_reg_load(atx_load), .divisor_load(div_load), .status_clear(stat_clr),
    .arx_reg_out(arx_odd), .arx_reg_read(rd_odd), .status_out(st_odd),
    .arx_fifo_empty(e_o), .arx_fifo_full(f_o), .arx_busy(b_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_div(input logic [15:0] v);
    @(negedge clk); data_in = v; div_load = 1'b1;
    @(negedge clk); div_load = 1'b0;
  endtask

  task automatic push_tx(input logic [7:0] v);
    @(negedge clk); data_in = {8'h00, v}; atx_load = 1'b1;
    @(negedge clk); atx_load = 1'b0;
  endtask

  task automatic pop_main();
    @(negedge clk); rd_main = 1'b1;
    @(negedge clk); rd_main = 1'b0;
  endtask

  task automatic pop_odd();
    @(negedge clk); rd_odd = 1'b1;
    @(negedge clk); rd_odd = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  // Drives n line bits LSB first, 4 cycles each (divisor 1), then leaves the line idle.
  task automatic drive_frame(input logic [15:0] bits, input int n, input bit to_odd);
    for (int i = 0; i < n; i++) begin
      if (to_odd) rx_odd = bits[i]; else rx_main_drv = bits[i];
      repeat (4) @(negedge clk);
    end
    rx_odd = 1'b1;
    rx_main_drv = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  exp_frame;
    logic [7:0]  rx_chars [5];
    bit          found;
    int          idx, low_cnt, busy_cnt;

    rst = 1'b1; data_in = '0; atx_load = 1'b0; div_load = 1'b0; stat_clr = 1'b0;
    rd_main = 1'b0; rd_odd = 1'b0; rx_main_drv = 1'b1; rx_odd = 1'b1; loop_en = 1'b0;
    cycles(3);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_status", st_main, 16'h0009);
    check("rst_tx_line", 16'(tx_main), 16'h0001);
    check("rst_arx_out", arx_main, 16'h0000);
    check("rst_flags", {13'b0, b_m, f_m, e_m}, 16'h0001);

    // Default divisor 54: start bit lasts 4 * 54 cycles
    push_tx(8'hFF);
    found = 1'b0;
    for (int i = 0; i < 120 && !found; i++) begin
      @(negedge clk);
      if (tx_main == 1'b0) found = 1'b1;
    end
    check("dflt_start_seen", 16'(found), 16'h0001);
    low_cnt = 1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx_main != 1'b0) break;
      low_cnt++;
    end
    check("dflt_start_len", 16'(low_cnt), 16'd216);
    pulse_reset();
    check("dflt_abort_line", 16'(tx_main), 16'h0001);

    // 8N1 transmit of 0xA5 with divisor 1
    load_div(16'd1);
    exp_frame = {1'b1, 8'hA5, 1'b0};
    push_tx(8'hA5);
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      @(negedge clk);
      if (tx_main == 1'b0) found = 1'b1;
    end
    check("t1_start_latency", 16'(found), 16'h0001);
    idx = 0;
    for (int b = 0; b < 10; b++) begin
      while (idx < 4 * b + 2) begin @(negedge clk); idx++; end
      check($sformatf("t1_bit%0d", b), 16'(tx_main), 16'(exp_frame[b]));
      check($sformatf("t1_busy%0d", b), 16'(st_main[5]), 16'h0001);
    end
    while (idx < 39) begin @(negedge clk); idx++; end
    check("t1_busy_last", 16'(st_main[5]), 16'h0001);
    @(negedge clk);
    check("t1_idle_after", st_main, 16'h0009);

    // Loopback, two characters back to back
    loop_en = 1'b1;
    push_tx(8'h3C);
    push_tx(8'hC3);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (st_main[15:8] == 8'd2) found = 1'b1;
    end
    check("lb_count2", {8'h00, st_main[15:8]}, 16'd2);
    check("lb_head0", arx_main, 16'h003C);
    pop_main();
    check("lb_head1", arx_main, 16'h00C3);
    check("lb_count1", {8'h00, st_main[15:8]}, 16'd1);
    pop_main();
    check("lb_empty_out", arx_main, 16'h0000);
    cycles(4);
    check("lb_status", st_main, 16'h0009);
    loop_en = 1'b0;

    // Odd parity: 0x01 needs parity bit 0
    @(negedge clk);
    drive_frame({5'b0, 1'b1, 1'b1, 8'h01, 1'b0}, 11, 1'b1);
    cycles(4);
    check("par_bad", arx_odd, 16'h8001);
    pop_odd();
    drive_frame({5'b0, 1'b1, 1'b0, 8'h01, 1'b0}, 11, 1'b1);
    cycles(4);
    check("par_good", arx_odd, 16'h0001);
    pop_odd();
    drive_frame({5'b0, 1'b0, 1'b0, 8'h01, 1'b0}, 11, 1'b1);
    cycles(8);
    check("framing_err", arx_odd, 16'h4001);
    check("framing_count", {8'h00, st_odd[15:8]}, 16'd1);
    pop_odd();
    cycles(4);
    check("odd_status", st_odd, 16'h0009);

    // RX overrun with a 4-deep FIFO
    rx_chars = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) drive_frame({6'b0, 1'b1, rx_chars[i], 1'b0}, 10, 1'b0);
    cycles(4);
    check("ovr_status", st_main, 16'h044A);
    check("ovr_head", arx_main, 16'h0011);
    @(negedge clk); stat_clr = 1'b1;
    @(negedge clk); stat_clr = 1'b0;
    check("ovr_cleared", st_main, 16'h040A);
    pop_main();
    check("ovr_pop1", arx_main, 16'h0022);
    pop_main();
    pop_main();
    check("ovr_pop3", arx_main, 16'h0044);
    pop_main();
    check("ovr_drained", arx_main, 16'h0000);
    check("ovr_drained_st", st_main, 16'h0009);

    // Start glitch: one-tick low pulse
    @(negedge clk); rx_main_drv = 1'b0;
    @(negedge clk); rx_main_drv = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (st_main[2]) busy_cnt++;
    end
    check("glitch_busy_len", 16'(busy_cnt), 16'd2);
    check("glitch_status", st_main, 16'h0009);

    // TX overflow; the last load coincides with status_clear
    load_div(16'd1000);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      data_in = 16'(i); atx_load = 1'b1; stat_clr = (i == 5);
    end
    @(negedge clk); atx_load = 1'b0; stat_clr = 1'b0;
    check("txovf_status", st_main, 16'h0091);
    @(negedge clk); stat_clr = 1'b1;
    @(negedge clk); stat_clr = 1'b0;
    check("txovf_cleared", st_main, 16'h0011);

    // Reset mid-frame with three bytes queued
    pulse_reset();
    check("rst2_status", st_main, 16'h0009);
    load_div(16'd1);
    loop_en = 1'b1;
    push_tx(8'h5A);
    push_tx(8'h01);
    push_tx(8'h02);
    push_tx(8'h03);
    cycles(10);
    check("midframe_busy", {st_main[5], st_main[3]}, 16'b10);
    pulse_reset();
    check("midrst_line", 16'(tx_main), 16'h0001);
    check("midrst_status", st_main, 16'h0009);
    check("midrst_arx", arx_main, 16'h0000);
    low_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx_main == 1'b0) low_cnt++;
    end
    check("midrst_no_frame", 16'(low_cnt), 16'd0);
    check("midrst_status_end", st_main, 16'h0009);
    loop_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
